// File: rtl/mos6502_int_seq.sv
// mos6502_int_seq: reset / NMI / BRK / IRQ sequencer for the mos6502 core.
// Arbitrates requests at instruction boundaries, runs the 7-cycle push and
// vector-fetch sequence on the shared bus, then pulses pc_load with the new
// PC and S. Define IRQ_VECTOR_TABLE_EN to give IRQ source k its own vector at
// IRQ_VEC - 2*(k+1) - 4 (descending table below NMI_VEC); BRK keeps IRQ_VEC.
//
// state  | meaning
// IDLE   | core owns the bus; waits for pending reset or a granted poll
// T0,T1  | dummy reads at pc_in
// T2..T4 | push PCH, PCL, P (plain reads for a reset sequence)
// T5,T6  | vector low / high byte reads
// LOAD   | pc_load pulse with pc_new / s_new
module mos6502_int_seq #(
    parameter int                ADDR_W     = 16,
    parameter int                DATA_W     = 8,
    parameter int                N_IRQ      = 4,
    parameter logic [7:0]        STACK_PAGE = 8'h01,
    parameter logic [ADDR_W-1:0] NMI_VEC    = ADDR_W'(16'hFFFA),
    parameter logic [ADDR_W-1:0] RES_VEC    = ADDR_W'(16'hFFFC),
    parameter logic [ADDR_W-1:0] IRQ_VEC    = ADDR_W'(16'hFFFE),
    localparam int               IDW        = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic              clk,
    input  logic              res,
    input  logic              rdy,
    input  logic              NMI,
    input  logic [N_IRQ-1:0]  IRQ,
    input  logic [DATA_W-1:0] d_in,
    output logic [ADDR_W-1:0] add_bus,
    output logic [DATA_W-1:0] d_out,
    output logic              write_en,
    input  logic              poll,
    input  logic              brk_req,
    input  logic              i_flag,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [7:0]        p_in,
    input  logic [7:0]        s_in,
    output logic              seq_busy,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_new,
    output logic [7:0]        s_new,
    output logic [IDW-1:0]    irq_id
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_LOAD
    } state_t;

    typedef enum logic [1:0] {K_RES, K_NMI, K_BRK, K_IRQ} kind_t;

    state_t            state;
    kind_t             kind;
    logic              res_pend;
    logic              nmi_prev;
    logic              nmi_pend;
    logic [DATA_W-1:0] vec_lo;

    logic              nmi_edge;
    logic              stall;
    logic              irq_any;
    logic              vec_is_nmi;
    logic [IDW-1:0]    irq_sel;
    logic [7:0]        push_p;
    logic [ADDR_W-1:0] vec_addr;

    function automatic logic [ADDR_W-1:0] stack_addr(input logic [7:0] s);
        return ADDR_W'({STACK_PAGE, s});
    endfunction

    // Lowest-index active (low) IRQ source
    always_comb begin
        irq_any = 1'b0;
        irq_sel = '0;
        for (int k = N_IRQ - 1; k >= 0; k--) begin
            if (!IRQ[k]) begin
                irq_any = 1'b1;
                irq_sel = IDW'(k);
            end
        end
    end

    // Stall qualification, pushed status byte and vector choice for T4 -> T5
    always_comb begin
        nmi_edge = nmi_prev & ~NMI;
        case (state)
            S_T0, S_T1, S_T5, S_T6: stall = ~rdy;
            S_T2, S_T3, S_T4:       stall = ~rdy & (kind == K_RES);
            default:                stall = 1'b0;
        endcase
        push_p = (p_in | 8'h20) & 8'hEF;
        if (kind == K_BRK)
            push_p = push_p | 8'h10;
        // An NMI pending by T4 steals a BRK/IRQ sequence; the pushed B bit stays.
        vec_is_nmi = (kind == K_NMI) || (nmi_pend && (kind == K_BRK || kind == K_IRQ));
`ifdef IRQ_VECTOR_TABLE_EN
        vec_addr = (kind == K_IRQ) ? IRQ_VEC - ADDR_W'(2 * (int'(irq_id) + 1) + 4) : IRQ_VEC;
`else
        vec_addr = IRQ_VEC;
`endif
        if (vec_is_nmi)
            vec_addr = NMI_VEC;
        if (kind == K_RES)
            vec_addr = RES_VEC;
    end

    // Sequencer FSM; bus outputs are registered together with the state
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state    <= S_IDLE;
            kind     <= K_RES;
            res_pend <= 1'b1;
            nmi_prev <= 1'b1;
            nmi_pend <= 1'b0;
            vec_lo   <= '0;
            add_bus  <= '0;
            d_out    <= '0;
            write_en <= 1'b1;
            seq_busy <= 1'b0;
            pc_load  <= 1'b0;
            pc_new   <= '0;
            s_new    <= '0;
            irq_id   <= '0;
        end else begin
            nmi_prev <= NMI;
            if (nmi_edge)
                nmi_pend <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (res_pend || (poll && (nmi_pend || brk_req || (irq_any && !i_flag)))) begin
                        state    <= S_T0;
                        seq_busy <= 1'b1;
                        add_bus  <= pc_in;
                        write_en <= 1'b1;
                        res_pend <= 1'b0;
                        if (res_pend)
                            kind <= K_RES;
                        else if (nmi_pend)
                            kind <= K_NMI;
                        else if (brk_req)
                            kind <= K_BRK;
                        else begin
                            kind   <= K_IRQ;
                            irq_id <= irq_sel;
                        end
                    end
                end
                S_T0: if (!stall) state <= S_T1;
                S_T1: if (!stall) begin
                    state    <= S_T2;
                    add_bus  <= stack_addr(s_in);
                    d_out    <= DATA_W'(pc_in >> 8);
                    write_en <= (kind == K_RES);
                end
                S_T2: if (!stall) begin
                    state   <= S_T3;
                    add_bus <= stack_addr(s_in - 8'd1);
                    d_out   <= DATA_W'(pc_in[7:0]);
                end
                S_T3: if (!stall) begin
                    state   <= S_T4;
                    add_bus <= stack_addr(s_in - 8'd2);
                    d_out   <= DATA_W'(push_p);
                end
                S_T4: if (!stall) begin
                    state    <= S_T5;
                    add_bus  <= vec_addr;
                    write_en <= 1'b1;
                    // Consume the pending NMI; an edge on this very clock survives.
                    if (vec_is_nmi)
                        nmi_pend <= nmi_edge;
                end
                S_T5: if (!stall) begin
                    state   <= S_T6;
                    vec_lo  <= d_in;
                    add_bus <= add_bus + ADDR_W'(1);
                end
                S_T6: if (!stall) begin
                    state   <= S_LOAD;
                    pc_load <= 1'b1;
                    pc_new  <= ADDR_W'({d_in, vec_lo});
                    s_new   <= s_in - 8'd3;
                end
                S_LOAD: begin
                    state    <= S_IDLE;
                    pc_load  <= 1'b0;
                    seq_busy <= 1'b0;
                    add_bus  <= '0;
                    d_out    <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mos6502_int_seq.sv
// Testbench for mos6502_int_seq (default build, IRQ_VECTOR_TABLE_EN undefined).
module tb_mos6502_int_seq;

    logic        clk = 1'b0;
    logic        res, rdy, NMI, poll, brk_req, i_flag;
    logic [3:0]  IRQ;
    logic [7:0]  d_in, d_out, p_in, s_in, s_new;
    logic [15:0] add_bus, pc_in, pc_new;
    logic        write_en, seq_busy, pc_load;
    logic [1:0]  irq_id;

    logic [7:0]  vmem [16];
    logic [23:0] wq[$];
    logic [15:0] rq[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          last_id;
    bit          nmi_m;

    always #5 clk = ~clk;

    assign d_in = (add_bus[15:4] == 12'hFFF) ? vmem[add_bus[3:0]] : 8'hEA;

    mos6502_int_seq dut (
        .clk(clk), .res(res), .rdy(rdy), .NMI(NMI), .IRQ(IRQ), .d_in(d_in),
        .add_bus(add_bus), .d_out(d_out), .write_en(write_en), .poll(poll),
        .brk_req(brk_req), .i_flag(i_flag), .pc_in(pc_in), .p_in(p_in), .s_in(s_in),
        .seq_busy(seq_busy), .pc_load(pc_load), .pc_new(pc_new), .s_new(s_new),
        .irq_id(irq_id)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic record();
        if (seq_busy && !write_en)
            wq.push_back({add_bus, d_out});
        if (seq_busy && write_en && add_bus[15:4] == 12'hFFF &&
            (rq.size() == 0 || rq[rq.size()-1] != add_bus))
            rq.push_back(add_bus);
    endtask

    // Caller has set up the request; the first edge here must start the sequence.
    // The model walks the 8 bus cycles: reads wait on rdy, pushes never do.
    task automatic run_seq(input string tag, input bit is_res, input bit is_brk, input bit rand_rdy,
                           input int hold_at, input int hold_len, input int nmi_at,
                           input logic [15:0] vec, input int exp_id);
        logic [15:0] pc, vec1, exp_pc;
        logic [7:0]  p, s, s1, s2, s3, exp_p;
        logic [23:0] e0, e1, e2;
        int          n, pos, exp_n;
        bit          rd;
        pc = pc_in; p = p_in; s = s_in;
        s1 = s - 8'd1; s2 = s - 8'd2; s3 = s - 8'd3;
        exp_p = ((p | 8'h20) & 8'hEF) | (is_brk ? 8'h10 : 8'h00);
        e0 = {8'h01, s, pc[15:8]};
        e1 = {8'h01, s1, pc[7:0]};
        e2 = {8'h01, s2, exp_p};
        vec1 = vec + 16'd1;
        exp_pc = {vmem[vec1[3:0]], vmem[vec[3:0]]};
        wq.delete();
        rq.delete();
        tick();
        n = 1; pos = 0; exp_n = 0;
        poll = 0; brk_req = 0; IRQ = 4'hF;
        record();
        while (n < 120 && pc_load !== 1'b1) begin
            if (rand_rdy) rdy = ($urandom_range(0, 3) != 0);
            else          rdy = !(n >= hold_at && n < hold_at + hold_len);
            if (n == nmi_at) NMI = 1'b0;
            rd = (pos <= 1) || (pos >= 5) || is_res;
            if (pos < 7 && !(rd && !rdy)) pos++;
            if (pos == 7 && exp_n == 0) exp_n = n + 1;
            tick();
            n++;
            record();
        end
        rdy = 1'b1;
        check({tag, "_load"}, pc_load, 1'b1);
        check({tag, "_lat"}, n, exp_n);
        check({tag, "_nwr"}, wq.size(), is_res ? 0 : 3);
        if (!is_res && wq.size() == 3) begin
            check({tag, "_pch"}, wq[0], e0);
            check({tag, "_pcl"}, wq[1], e1);
            check({tag, "_p"},   wq[2], e2);
        end
        check({tag, "_vaddr"}, (rq.size() == 2) ? {rq[0], rq[1]} : 32'h0, {vec, vec1});
        check({tag, "_pcnew"}, pc_new, exp_pc);
        check({tag, "_snew"}, s_new, s3);
        check({tag, "_id"}, irq_id, exp_id);
        tick();
        check({tag, "_idle"}, {seq_busy, pc_load}, 2'b00);
    endtask

    initial begin
        int busy_cnt, id;
        bit brk;
        res = 1'b1; rdy = 1'b1; NMI = 1'b1; IRQ = 4'hF;
        poll = 1'b0; brk_req = 1'b0; i_flag = 1'b1;
        pc_in = 16'h0200; p_in = 8'h00; s_in = 8'hFD;
        for (int i = 0; i < 16; i++) vmem[i] = 8'($urandom);
        vmem[12] = 8'h00;
        vmem[13] = 8'h80;
        nmi_m = 1'b0;
        last_id = 0;

        // reset state and reset sequence
        #3 res = 1'b0;
        tick(); tick();
        check("rst_bus", {add_bus, d_out, write_en, seq_busy, pc_load}, {16'h0, 8'h0, 1'b1, 1'b0, 1'b0});
        check("rst_ld", {pc_new, s_new, irq_id}, 26'h0);
        res = 1'b1;
        run_seq("res", 1, 0, 0, 0, 0, 0, 16'hFFFC, 0);
        check("res_pc", pc_new, 16'h8000);

        // IRQ[2] with the documented push pattern
        pc_in = 16'h1234; s_in = 8'hFF; p_in = 8'h00;
        IRQ = 4'b1011; i_flag = 1'b0; poll = 1'b1;
        run_seq("irq2", 0, 0, 0, 0, 0, 0, 16'hFFFE, 2);
        last_id = 2;

        // masked IRQs, then unmasked: lowest index wins
        IRQ = 4'b0110; i_flag = 1'b1; poll = 1'b1;
        tick(); tick();
        check("masked", seq_busy, 1'b0);
        i_flag = 1'b0;
        run_seq("irq0", 0, 0, 0, 0, 0, 0, 16'hFFFE, 0);
        last_id = 0;

        // BRK hijacked by an NMI falling in T3
        i_flag = 1'b1; pc_in = 16'h4567; s_in = 8'h80; p_in = 8'hC3;
        brk_req = 1'b1; poll = 1'b1;
        run_seq("brk_nmi", 0, 1, 0, 0, 0, 4, 16'hFFFA, last_id);
        poll = 1'b1;
        tick(); tick();
        poll = 1'b0;
        check("nmi_clr", seq_busy, 1'b0);
        NMI = 1'b1;
        tick();

        // NMI held low: one sequence only, T5 stretched by rdy
        NMI = 1'b0;
        tick();
        pc_in = 16'h0A0B; s_in = 8'h02; p_in = 8'h10; poll = 1'b1;
        run_seq("nmi_hold", 0, 0, 0, 6, 3, 0, 16'hFFFA, last_id);
        busy_cnt = 0;
        poll = 1'b1;
        for (int i = 0; i < 90; i++) begin
            tick();
            if (seq_busy) busy_cnt++;
        end
        poll = 1'b0;
        check("nmi_once", busy_cnt, 0);
        NMI = 1'b1;
        tick();

        // NMI edge in T6 of an IRQ sequence is kept for the next poll
        IRQ = 4'b0111; i_flag = 1'b0; poll = 1'b1;
        run_seq("irq3_late", 0, 0, 0, 0, 0, 7, 16'hFFFE, 3);
        last_id = 3;
        NMI = 1'b1; poll = 1'b1;
        run_seq("nmi_late", 0, 0, 0, 0, 0, 0, 16'hFFFA, 3);

        // reset in the middle of a sequence
        IRQ = 4'b1101; i_flag = 1'b0; poll = 1'b1;
        tick();
        poll = 1'b0;
        tick(); tick(); tick();
        res = 1'b0;
        tick();
        check("abort_bus", {add_bus, d_out, write_en, seq_busy, pc_load}, {16'h0, 8'h0, 1'b1, 1'b0, 1'b0});
        check("abort_ld", {pc_new, s_new, irq_id}, 26'h0);
        IRQ = 4'hF; res = 1'b1; last_id = 0;
        run_seq("res2", 1, 0, 0, 0, 0, 0, 16'hFFFC, 0);

        // randomized requests with random rdy stalls
        for (int t = 0; t < 40; t++) begin
            pc_in  = 16'($urandom_range(0, 16'hEFFF));
            p_in   = 8'($urandom);
            s_in   = 8'($urandom);
            IRQ    = 4'($urandom);
            i_flag = 1'($urandom);
            brk    = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) begin
                NMI = 1'b0;
                tick();
                NMI = 1'b1;
                nmi_m = 1'b1;
            end
            brk_req = brk;
            poll = 1'b1;
            if (nmi_m) begin
                run_seq("rnd_nmi", 0, 0, 1, 0, 0, 0, 16'hFFFA, last_id);
                nmi_m = 1'b0;
            end else if (brk) begin
                run_seq("rnd_brk", 0, 1, 1, 0, 0, 0, 16'hFFFE, last_id);
            end else if (!i_flag && IRQ != 4'hF) begin
                id = 0;
                for (int k = 3; k >= 0; k--)
                    if (!IRQ[k]) id = k;
                last_id = id;
                run_seq("rnd_irq", 0, 0, 1, 0, 0, 0, 16'hFFFE, id);
            end else begin
                tick();
                poll = 1'b0;
                brk_req = 1'b0;
                tick();
                check("rnd_none", seq_busy, 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
